unpacker32to8: RTL and testbench

Unpacks 32-bit words from the capture FIFO read port into a little-endian byte stream for a byte-wide output link. It mirrors `packer8to32` exactly: byte 0 (bits [7:0]) leaves first and bits [31:24] leave last, so packing followed by unpacking reproduces the original byte order. A one-word prefetch slot hides the FIFO's one-cycle read latency, which sustains one byte per clock while the consumer is ready.

---
 rtl/unpacker32to8_pkg.sv | 19 +
 rtl/unpacker32to8.sv | 126 ++++++++++++
 tb/tb_unpacker32to8.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/unpacker32to8_pkg.sv
// Shared sizing constants for the byte-link packer/unpacker pair.
// The packer and unpacker must agree on word and byte widths, so both
// take their defaults from here.
package unpacker32to8_pkg;

   // FIFO word width; always four link bytes.
   localparam int UNPK_DATA_LEN  = 32;
   // Link byte width.
   localparam int UNPK_LVDS_LEN  = 8;
   // Bytes carried by one FIFO word.
   localparam int BYTES_PER_WORD = 4;

   // Width of the byte-position counter inside a word.
   localparam int BCNT_W = $clog2(BYTES_PER_WORD);

   // Position of the final (most significant) byte of a word.
   localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);

endpackage : unpacker32to8_pkg

// File: rtl/unpacker32to8.sv
// Unpacks 32-bit FIFO words into a little-endian byte stream.
// Byte 0 (bits [7:0]) leaves first and bits [31:24] leave last, mirroring
// packer8to32. A one-word prefetch slot covers the FIFO's one-cycle read
// latency so a ready consumer sees one byte per clock without bubbles.
module unpacker32to8
   import unpacker32to8_pkg::*;
#(
   parameter int DATA_LEN = UNPK_DATA_LEN,
   parameter int LVDS_LEN = UNPK_LVDS_LEN
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                fifo_empty,
   output logic                fifo_rd_en,
   input  logic [DATA_LEN-1:0] fifo_data,
   input  logic                ready_in,
   output logic                valid_out,
   output logic [LVDS_LEN-1:0] data_out,
   output logic                busy
);

   // Word currently being emitted, byte by byte.
   logic [DATA_LEN-1:0] cur_word_q, cur_word_d;
   logic                cur_valid_q, cur_valid_d;
   logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;

   // Prefetched word waiting behind the current one.
   logic [DATA_LEN-1:0] pf_word_q, pf_word_d;
   logic                pf_valid_q, pf_valid_d;

   // A read was issued last cycle; fifo_data is valid this cycle.
   logic                pending_q, pending_d;

   // Holds off reads for the first cycle after reset release.
   logic                run_q, run_d;

   logic                xfer;
   logic                last_xfer;

   // Read strobe: one read in flight at most, and only while the prefetch
   // slot is free, so back-pressure caps storage at two words.
   assign fifo_rd_en = run_q & ~fifo_empty & ~pending_q & ~pf_valid_q;

   assign xfer       = cur_valid_q & ready_in;
   assign last_xfer  = xfer & (byte_cnt_q == LAST_BYTE);

   assign valid_out  = cur_valid_q;
   assign busy       = cur_valid_q | pf_valid_q | pending_q;

   // Next-state logic: byte advance, word hand-over and read capture.
   always_comb begin
      // NOTE: every _d starts as its _q so no path through this block
      // leaves a signal unassigned and infers a latch.
      cur_word_d  = cur_word_q;
      cur_valid_d = cur_valid_q;
      byte_cnt_d  = byte_cnt_q;
      pf_word_d   = pf_word_q;
      pf_valid_d  = pf_valid_q;
      pending_d   = fifo_rd_en;
      run_d       = 1'b1;

      if (xfer) begin
         // Wraps to 0 after the last byte.
         byte_cnt_d = byte_cnt_q + 1'b1;
      end

      // Word finished: refill from the prefetch slot first, otherwise from
      // the read landing this cycle, otherwise go idle.
      if (last_xfer) begin
         if (pf_valid_q) begin
            cur_word_d = pf_word_q;
            pf_valid_d = 1'b0;
         end else if (!pending_q) begin
            cur_valid_d = 1'b0;
         end
      end

      // Read data lands: straight into cur when it is free or being vacated,
      // else into the prefetch slot. pending and pf_valid are never both set,
      // because a read is only issued while the prefetch slot is empty.
      if (pending_q) begin
         if (!cur_valid_q || last_xfer) begin
            cur_word_d  = fifo_data;
            cur_valid_d = 1'b1;
            byte_cnt_d  = '0;
         end else begin
            pf_word_d  = fifo_data;
            pf_valid_d = 1'b1;
         end
      end
   end

   // Byte select; drives zero while no word is held.
   always_comb begin
      data_out = '0;
      if (cur_valid_q) begin
         data_out = cur_word_q[LVDS_LEN*int'(byte_cnt_q) +: LVDS_LEN];
      end
   end

   // State registers; reset discards any partial word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the word registers are reset too, so data_out and the
         // prefetch slot never expose stale data after a reset.
         cur_word_q  <= '0;
         cur_valid_q <= 1'b0;
         byte_cnt_q  <= '0;
         pf_word_q   <= '0;
         pf_valid_q  <= 1'b0;
         pending_q   <= 1'b0;
         run_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         cur_word_q  <= cur_word_d;
         cur_valid_q <= cur_valid_d;
         byte_cnt_q  <= byte_cnt_d;
         pf_word_q   <= pf_word_d;
         pf_valid_q  <= pf_valid_d;
         pending_q   <= pending_d;
         run_q       <= run_d;
      end
   end

endmodule : unpacker32to8

// File: tb/tb_unpacker32to8.sv
// Directed bench for unpacker32to8 with a one-cycle-latency FIFO model.
// Inputs change 1 ns after the rising edge; outputs are read 1 ns after
// the falling edge. Accepted bytes are logged on the falling edge.
module tb_unpacker32to8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [31:0] fifo_data = '0;
   logic        ready_in = 1'b0;
   logic        valid_out;
   logic [7:0]  data_out;
   logic        busy;

   unpacker32to8 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_data  (fifo_data),
      .ready_in   (ready_in),
      .valid_out  (valid_out),
      .data_out   (data_out),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // FIFO model: written by the stimulus, popped by the DUT strobe,
   // data returned one cycle after the strobe.
   logic [31:0] mem [0:127];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_data <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Log of accepted bytes and the cycle each one was presented.
   logic [7:0] out_b [0:255];
   int         out_c [0:255];
   int         out_cnt = 0;

   always @(negedge clk) begin
      if (valid_out && ready_in && out_cnt < 256) begin
         out_b[out_cnt] <= data_out;
         out_c[out_cnt] <= cyc;
         out_cnt        <= out_cnt + 1;
      end
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] w);
      mem[wr_ptr] = w;
      wr_ptr++;
   endtask

   task automatic neg();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_bytes(input int n, input int budget);
      int k = 0;
      while (out_cnt < n && k < budget) begin
         neg();
         k++;
      end
      check("byte_count", 32'(out_cnt), 32'(n));
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (busy && k < budget) begin
         neg();
         k++;
      end
      check("idle", 32'(busy), 32'h0);
   endtask

   int         rd_cyc;
   int         base;
   int         rd0;
   int         k;
   logic [7:0] exp_b [0:39];

   initial begin
      // ---------------- reset with a non-empty FIFO ----------------
      push(32'hDDCCBBAA);
      ready_in = 1'b1;
      rst_n    = 1'b0;
      neg();
      neg();
      check("rst_rd_en",  32'(fifo_rd_en), 32'h0);
      check("rst_valid",  32'(valid_out),  32'h0);
      check("rst_data",   32'(data_out),   32'h0);
      check("rst_busy",   32'(busy),       32'h0);

      @(posedge clk);
      #1;
      rst_n = 1'b1;
      neg();
      check("no_strobe_release_cycle", 32'(fifo_rd_en), 32'h0);
      neg();
      check("first_strobe", 32'(fifo_rd_en), 32'h1);
      rd_cyc = cyc;

      // ---------------- single word ----------------
      wait_bytes(4, 20);
      check("single_b0", 32'(out_b[0]), 32'hAA);
      check("single_b1", 32'(out_b[1]), 32'hBB);
      check("single_b2", 32'(out_b[2]), 32'hCC);
      check("single_b3", 32'(out_b[3]), 32'hDD);
      for (int i = 0; i < 4; i++) begin
         check("single_cycle", 32'(out_c[i]), 32'(rd_cyc + 2 + i));
      end
      neg();
      check("single_valid_drop", 32'(valid_out), 32'h0);
      check("single_busy_drop",  32'(busy),      32'h0);

      // ---------------- streaming ----------------
      base = out_cnt;
      push(32'h03020100);
      push(32'h07060504);
      push(32'h0B0A0908);
      wait_bytes(base + 12, 40);
      for (int i = 0; i < 12; i++) begin
         check("stream_byte", 32'(out_b[base + i]), 32'(i));
      end
      for (int i = 1; i < 12; i++) begin
         check("stream_no_bubble", 32'(out_c[base + i]), 32'(out_c[base + i - 1] + 1));
      end
      wait_idle(20);

      // ---------------- back-pressure ----------------
      base = out_cnt;
      rd0  = rd_ptr;
      push(32'h03020100);
      push(32'h07060504);
      push(32'h0B0A0908);
      k = 0;
      while (!(valid_out && data_out == 8'h00) && k < 20) begin
         neg();
         k++;
      end
      check("bp_first_byte", 32'(data_out), 32'h00);
      @(posedge clk);
      #1;
      ready_in = 1'b0;
      repeat (10) neg();
      check("bp_hold_data",  32'(data_out),     32'h01);
      check("bp_hold_valid", 32'(valid_out),    32'h1);
      check("bp_no_read",    32'(fifo_rd_en),   32'h0);
      check("bp_two_reads",  32'(rd_ptr - rd0), 32'h2);
      check("bp_busy",       32'(busy),         32'h1);
      @(posedge clk);
      #1;
      ready_in = 1'b1;
      wait_bytes(base + 12, 40);
      for (int i = 0; i < 12; i++) begin
         check("bp_byte", 32'(out_b[base + i]), 32'(i));
      end
      wait_idle(20);

      // ---------------- random bytes, random ready ----------------
      base = out_cnt;
      for (int i = 0; i < 40; i++) exp_b[i] = 8'($urandom_range(0, 255));
      for (int w = 0; w < 10; w++) begin
         push({exp_b[4*w+3], exp_b[4*w+2], exp_b[4*w+1], exp_b[4*w]});
      end
      k = 0;
      while (out_cnt < base + 40 && k < 600) begin
         @(posedge clk);
         #1;
         ready_in = 1'($urandom_range(0, 1));
         k++;
      end
      neg();
      check("loop_count", 32'(out_cnt), 32'(base + 40));
      for (int i = 0; i < 40; i++) begin
         check("loop_byte", 32'(out_b[base + i]), 32'(exp_b[i]));
      end
      @(posedge clk);
      #1;
      ready_in = 1'b1;
      wait_idle(20);

      // ---------------- reset mid-word ----------------
      base = out_cnt;
      push(32'h44332211);
      k = 0;
      while (!(valid_out && data_out == 8'h22) && k < 20) begin
         neg();
         k++;
      end
      @(posedge clk);
      #1;
      check("mid_pre_reset_byte", 32'(data_out), 32'h33);
      rst_n = 1'b0;
      #1;
      check("mid_async_valid", 32'(valid_out),  32'h0);
      check("mid_async_data",  32'(data_out),   32'h0);
      check("mid_async_busy",  32'(busy),       32'h0);
      check("mid_async_rd_en", 32'(fifo_rd_en), 32'h0);
      check("mid_logged",      32'(out_cnt),    32'(base + 2));
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      wr_ptr = rd_ptr;
      base   = out_cnt;
      push(32'h88776655);
      wait_bytes(base + 4, 20);
      check("mid_new_b0", 32'(out_b[base + 0]), 32'h55);
      check("mid_new_b1", 32'(out_b[base + 1]), 32'h66);
      check("mid_new_b2", 32'(out_b[base + 2]), 32'h77);
      check("mid_new_b3", 32'(out_b[base + 3]), 32'h88);
      wait_idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop in case a wait above never returns.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

endmodule : tb_unpacker32to8
